// File: rtl/ysyx_25040101_idu_ctrl_pkg.sv
// Shared constants for the decode-stage controller: RV32 opcodes, one-hot immediate
// format selects and the skid-buffer state encoding.
package ysyx_25040101_idu_ctrl_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [4:0] IMM_I    = 5'b10000;
    localparam logic [4:0] IMM_S    = 5'b01000;
    localparam logic [4:0] IMM_B    = 5'b00100;
    localparam logic [4:0] IMM_U    = 5'b00010;
    localparam logic [4:0] IMM_J    = 5'b00001;
    localparam logic [4:0] IMM_NONE = 5'b00000;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } idu_state_e;

endpackage

// File: rtl/ysyx_25040101_imm_type_dec.sv
// Combinational opcode classifier: one-hot immediate format select plus illegal flag.
module ysyx_25040101_imm_type_dec
    import ysyx_25040101_idu_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [4:0] imm_type_o,
    output logic       illegal_o
);

    // Every legal opcode ends in 2'b11, so the default arm also covers compressed encodings.
    always_comb begin
        imm_type_o = IMM_NONE;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_IMM, LOAD, JALR, SYSTEM: imm_type_o = IMM_I;
            STORE:                      imm_type_o = IMM_S;
            BRANCH:                     imm_type_o = IMM_B;
            LUI, AUIPC:                 imm_type_o = IMM_U;
            JAL:                        imm_type_o = IMM_J;
            OP:                         imm_type_o = IMM_NONE;
            default:                    illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25040101_idu_ctrl.sv
// Decode-stage controller: buffers fetched instructions in a 2-entry skid buffer (or a
// single entry), tags each with its immediate format and presents them to execute.
module ysyx_25040101_idu_ctrl
    import ysyx_25040101_idu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned EN_SKID = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ifu_valid_i,
    output logic              ifu_ready_o,
    input  logic [XLEN-1:0]   inst_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              flush_i,
    output logic              idu_valid_o,
    input  logic              exu_ready_i,
    output logic [XLEN-8:0]   inst_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [4:0]        imm_type_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    idu_state_e state_q, state_d;

    logic [XLEN-8:0]  main_inst_q, skid_inst_q;
    logic [XLEN-1:0]  main_pc_q, skid_pc_q;
    logic [4:0]       main_imm_q, skid_imm_q;
    logic             main_ill_q, skid_ill_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [4:0] cap_imm;
    logic       cap_ill;
    logic       up_xfer, dn_xfer, stall;
    logic       main_we, main_from_skid, skid_we;

    ysyx_25040101_imm_type_dec u_imm_type_dec (
        .opcode_i   (inst_i[6:0]),
        .imm_type_o (cap_imm),
        .illegal_o  (cap_ill)
    );

    assign idu_valid_o = (state_q != StEmpty);
    assign ifu_ready_o = (EN_SKID != 0) ? (state_q != StTwo) : (!idu_valid_o || exu_ready_i);
    assign up_xfer     = ifu_valid_i && ifu_ready_o;
    assign dn_xfer     = idu_valid_o && exu_ready_i;
    assign stall       = idu_valid_o && !exu_ready_i;

    always_comb begin
        state_d        = state_q;
        main_we        = 1'b0;
        main_from_skid = 1'b0;
        skid_we        = 1'b0;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (up_xfer) begin
                        state_d = StOne;
                        main_we = 1'b1;
                    end
                end
                StOne: begin
                    if (up_xfer && dn_xfer) begin
                        main_we = 1'b1;
                    end else if (up_xfer) begin
                        state_d = StTwo;
                        skid_we = 1'b1;
                    end else if (dn_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (dn_xfer) begin
                        state_d        = StOne;
                        main_we        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StEmpty;
            main_inst_q <= '0;
            main_pc_q   <= '0;
            main_imm_q  <= IMM_NONE;
            main_ill_q  <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_imm_q  <= IMM_NONE;
            skid_ill_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (main_we) begin
                if (main_from_skid) begin
                    main_inst_q <= skid_inst_q;
                    main_pc_q   <= skid_pc_q;
                    main_imm_q  <= skid_imm_q;
                    main_ill_q  <= skid_ill_q;
                end else begin
                    main_inst_q <= inst_i[XLEN-1:7];
                    main_pc_q   <= pc_i;
                    main_imm_q  <= cap_imm;
                    main_ill_q  <= cap_ill;
                end
            end
            if (skid_we) begin
                skid_inst_q <= inst_i[XLEN-1:7];
                skid_pc_q   <= pc_i;
                skid_imm_q  <= cap_imm;
                skid_ill_q  <= cap_ill;
            end
            if (stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign inst_o      = main_inst_q;
    assign pc_o        = main_pc_q;
    assign imm_type_o  = main_imm_q;
    assign illegal_o   = main_ill_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_25040101_idu_ctrl.sv
// Scoreboard bench: accepted instructions are queued with their expected decode; a monitor
// compares the held payload, handshake signals and stall count against a FIFO-occupancy model.
module tb_ysyx_25040101_idu_ctrl;

    typedef struct {
        logic [24:0] inst;
        logic [31:0] pc;
        logic [4:0]  imm;
        logic        ill;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        ifu_valid_i = 1'b0;
    logic        ifu_ready_o;
    logic [31:0] inst_i = '0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        idu_valid_o;
    logic        exu_ready_i = 1'b0;
    logic [24:0] inst_o;
    logic [31:0] pc_o;
    logic [4:0]  imm_type_o;
    logic        illegal_o;
    logic [31:0] stall_cnt_o;

    exp_t        q[$];
    int          occ = 0;
    logic [31:0] stall_m = '0;
    logic [31:0] pc_ctr = 32'h8000_0000;
    int          checks = 0;
    int          errors = 0;

    ysyx_25040101_idu_ctrl #(
        .XLEN    (32),
        .EN_SKID (1),
        .CNT_W   (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .ifu_valid_i (ifu_valid_i),
        .ifu_ready_o (ifu_ready_o),
        .inst_i      (inst_i),
        .pc_i        (pc_i),
        .flush_i     (flush_i),
        .idu_valid_o (idu_valid_o),
        .exu_ready_i (exu_ready_i),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .imm_type_o  (imm_type_o),
        .illegal_o   (illegal_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the opcode table.
    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc);
        exp_t       e;
        logic [6:0] op;
        op    = ins[6:0];
        e.inst = ins[31:7];
        e.pc   = pc;
        e.imm  = 5'b00000;
        e.ill  = 1'b0;
        if (op inside {7'h13, 7'h03, 7'h67, 7'h73}) e.imm = 5'b10000;
        else if (op == 7'h23)                       e.imm = 5'b01000;
        else if (op == 7'h63)                       e.imm = 5'b00100;
        else if (op inside {7'h37, 7'h17})          e.imm = 5'b00010;
        else if (op == 7'h6F)                       e.imm = 5'b00001;
        else if (op != 7'h33)                       e.ill = 1'b1;
        return e;
    endfunction

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy,
                         input logic fl);
        ifu_valid_i = v;
        inst_i      = ins;
        pc_i        = pc_ctr;
        exu_ready_i = rdy;
        flush_i     = fl;
        @(negedge clk_i);
        if (rst_n_i && v && occ < 2 && !fl) begin
            q.push_back(mk(ins, pc_ctr));
            pc_ctr = pc_ctr + 32'd4;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(idu_valid_o), 64'd0);
        chk({tag, "_ready"}, 64'(ifu_ready_o), 64'd1);
        chk({tag, "_imm"},   64'(imm_type_o),  64'd0);
        chk({tag, "_ill"},   64'(illegal_o),   64'd0);
        chk({tag, "_stall"}, 64'(stall_cnt_o), 64'd0);
    endtask

    // Monitor: runs at negedge+2, after the driver has queued this cycle's acceptance.
    always begin
        @(negedge clk_i);
        #2;
        if (!rst_n_i) begin
            q.delete();
            occ     = 0;
            stall_m = '0;
        end else begin
            chk("idu_valid", 64'(idu_valid_o), 64'(occ != 0));
            chk("ifu_ready", 64'(ifu_ready_o), 64'(occ < 2));
            chk("stall_cnt", 64'(stall_cnt_o), 64'(stall_m));
            if (occ != 0) begin
                if (q.size() == 0) begin
                    chk("scoreboard_nonempty", 64'(q.size()), 64'd1);
                end else begin
                    chk("inst_o",     64'(inst_o),     64'(q[0].inst));
                    chk("pc_o",       64'(pc_o),       64'(q[0].pc));
                    chk("imm_type_o", 64'(imm_type_o), 64'(q[0].imm));
                    chk("illegal_o",  64'(illegal_o),  64'(q[0].ill));
                end
                if (!exu_ready_i && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
                if (exu_ready_i && q.size() > 0) void'(q.pop_front());
            end
            if (flush_i) begin
                q.delete();
                occ = 0;
            end else begin
                occ = occ + ((ifu_valid_i && occ < 2) ? 1 : 0) - ((occ != 0 && exu_ready_i) ? 1 : 0);
            end
        end
    end

    initial begin
        logic [31:0] r, ins;
        logic [6:0]  ops [12];
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33,
                7'h7F, 7'h00};

        #1;
        chk_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // Single addi, then back-to-back mixed formats.
        cycle(1, 32'h0050_0093, 1, 0);
        cycle(1, 32'h0011_2623, 1, 0);
        cycle(1, 32'h0080_00EF, 1, 0);
        cycle(1, 32'hFE00_0EE3, 1, 0);
        cycle(1, 32'h1234_5037, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);

        // Stall while offering three instructions, then release.
        cycle(1, 32'h0010_0113, 0, 0);
        cycle(1, 32'h0020_0193, 0, 0);
        cycle(1, 32'h0030_0213, 0, 0);
        cycle(1, 32'h0030_0213, 0, 0);
        cycle(1, 32'h0030_0213, 0, 0);
        chk("stall_cnt_after_4", 64'(stall_cnt_o), 64'd4);
        for (int i = 0; i < 5; i++) cycle((occ < 2 && q.size() < 3) ? 1'b1 : 1'b0,
                                          32'h0030_0213, 1, 0);

        // Illegal and R-type encodings.
        cycle(1, 32'h0000_0000, 1, 0);
        cycle(1, 32'h0000_007F, 1, 0);
        cycle(1, 32'h0020_81B3, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);

        // Fill to two entries, then flush with a fresh instruction offered.
        cycle(1, 32'h0040_0293, 0, 0);
        cycle(1, 32'h0050_0313, 0, 0);
        cycle(1, 32'h0060_0393, 0, 1);
        chk("flush_valid", 64'(idu_valid_o), 64'd0);
        chk("flush_ready", 64'(ifu_ready_o), 64'd1);
        cycle(0, 32'h0, 1, 0);

        // Asynchronous reset in the middle of a two-entry stall.
        cycle(1, 32'h0070_0413, 0, 0);
        cycle(1, 32'h0080_0493, 0, 0);
        cycle(1, 32'h0090_0513, 0, 0);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        ifu_valid_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        cycle(0, 32'h0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom();
            ins = $urandom();
            if (r[3:0] != 4'hF) ins[6:0] = ops[r[7:4] % 12];
            cycle(r[8] | r[9], ins, r[10] | r[11], (r[19:14] == 6'd0) ? 1'b1 : 1'b0);
        end

        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 0);
        chk("drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
